// File: rtl/bsg_chip_reset_cord_sequencer.sv
// Reset/cord sequencer: joins per-domain tag resets, releases domains one by one in index order.
// Optional status ports (seq_count_o, abort_o) are enabled by defining BSG_RESET_SEQ_STATUS_EN.
module bsg_chip_reset_cord_sequencer #(
    parameter int num_domains_p       = 4,
    parameter int cord_width_p        = 7,
    parameter int min_assert_cycles_p = 8,
    parameter int stage_cycles_p      = 4
) (
    input  logic                                        clk_i,
    input  logic                                        reset_n_i,
    input  logic [num_domains_p-1:0]                    tag_v_i,
    input  logic [num_domains_p-1:0]                    tag_reset_i,
    input  logic [num_domains_p-1:0][cord_width_p-1:0]  tag_cord_i,
    output logic [num_domains_p-1:0]                    domain_reset_o,
    output logic [num_domains_p-1:0][cord_width_p-1:0]  domain_cord_o,
    output logic                                        all_released_o,
    output logic                                        busy_o
`ifdef BSG_RESET_SEQ_STATUS_EN
    ,
    output logic [7:0]                                  seq_count_o,
    output logic                                        abort_o
`endif
);

    localparam int AW = (min_assert_cycles_p > 1) ? $clog2(min_assert_cycles_p) : 1;
    localparam int SW = (stage_cycles_p > 1) ? $clog2(stage_cycles_p) : 1;
    localparam int IW = $clog2(num_domains_p + 1);

    localparam logic [AW-1:0] ASSERT_LAST = AW'(min_assert_cycles_p - 1);
    localparam logic [SW-1:0] STAGE_LAST  = SW'(stage_cycles_p - 1);
    localparam logic [IW-1:0] IDX_LAST    = IW'(num_domains_p - 1);

    typedef enum logic [1:0] {S_RESET, S_HOLD, S_RELEASE, S_RUN} state_e;

    state_e                                       state_q, state_d;
    logic [AW-1:0]                                assert_ctr_q, assert_ctr_d;
    logic [SW-1:0]                                stage_ctr_q, stage_ctr_d;
    logic [IW-1:0]                                idx_q, idx_d;
    logic [num_domains_p-1:0]                     domain_reset_q, domain_reset_d;
    logic [num_domains_p-1:0][cord_width_p-1:0]   cord_q, cord_d;
    logic                                         req;

    assign req = |tag_reset_i;

    always_comb begin
        state_d        = state_q;
        assert_ctr_d   = assert_ctr_q;
        stage_ctr_d    = stage_ctr_q;
        idx_d          = idx_q;
        domain_reset_d = domain_reset_q;
        unique case (state_q)
            S_RESET: begin
                // req is deliberately ignored here: the minimum assert window always runs out
                domain_reset_d = '1;
                if (assert_ctr_q == ASSERT_LAST) begin
                    state_d      = req ? S_HOLD : S_RELEASE;
                    assert_ctr_d = '0;
                    stage_ctr_d  = '0;
                    idx_d        = '0;
                end else begin
                    assert_ctr_d = assert_ctr_q + AW'(1);
                end
            end
            S_HOLD: begin
                domain_reset_d = '1;
                if (!req) begin
                    state_d     = S_RELEASE;
                    stage_ctr_d = '0;
                    idx_d       = '0;
                end
            end
            S_RELEASE: begin
                // an abort wins over a release step falling on the same edge
                if (req) begin
                    state_d        = S_RESET;
                    domain_reset_d = '1;
                    assert_ctr_d   = '0;
                    stage_ctr_d    = '0;
                    idx_d          = '0;
                end else if (stage_ctr_q == STAGE_LAST) begin
                    for (int k = 0; k < num_domains_p; k++) begin
                        if (idx_q == IW'(k)) domain_reset_d[k] = 1'b0;
                    end
                    stage_ctr_d = '0;
                    idx_d       = idx_q + IW'(1);
                    if (idx_q == IDX_LAST) state_d = S_RUN;
                end else begin
                    stage_ctr_d = stage_ctr_q + SW'(1);
                end
            end
            S_RUN: begin
                if (req) begin
                    state_d        = S_RESET;
                    domain_reset_d = '1;
                    assert_ctr_d   = '0;
                    stage_ctr_d    = '0;
                    idx_d          = '0;
                end
            end
            default: begin
                state_d        = S_RESET;
                domain_reset_d = '1;
                assert_ctr_d   = '0;
                stage_ctr_d    = '0;
                idx_d          = '0;
            end
        endcase
    end

    // cord follows the tag client only while its domain is (registered) in reset
    for (genvar k = 0; k < num_domains_p; k++) begin : g_cord
        assign cord_d[k] = (tag_v_i[k] && domain_reset_q[k]) ? tag_cord_i[k] : cord_q[k];
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_q        <= S_RESET;
            assert_ctr_q   <= '0;
            stage_ctr_q    <= '0;
            idx_q          <= '0;
            domain_reset_q <= '1;
            cord_q         <= '0;
        end else begin
            state_q        <= state_d;
            assert_ctr_q   <= assert_ctr_d;
            stage_ctr_q    <= stage_ctr_d;
            idx_q          <= idx_d;
            domain_reset_q <= domain_reset_d;
            cord_q         <= cord_d;
        end
    end

    assign domain_reset_o = domain_reset_q;
    assign domain_cord_o  = cord_q;
    assign all_released_o = (state_q == S_RUN);
    assign busy_o         = (state_q != S_RUN);

`ifdef BSG_RESET_SEQ_STATUS_EN
    logic [7:0] seq_count_q, seq_count_d;
    logic       abort_q, abort_d;
    logic       seq_done, seq_abort;

    assign seq_done  = (state_q == S_RELEASE) && (state_d == S_RUN);
    assign seq_abort = (state_q == S_RELEASE) && req;

    always_comb begin
        seq_count_d = seq_count_q;
        abort_d     = abort_q;
        if (seq_done && seq_count_q != 8'hFF) seq_count_d = seq_count_q + 8'd1;
        if (seq_abort) abort_d = 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            seq_count_q <= '0;
            abort_q     <= 1'b0;
        end else begin
            seq_count_q <= seq_count_d;
            abort_q     <= abort_d;
        end
    end

    assign seq_count_o = seq_count_q;
    assign abort_o     = abort_q;
`endif

endmodule
